// File: rtl/mips_alu_unit.sv
// ============================================================================
// mips_alu_unit : registered 32-bit EX-stage ALU (shifts, MUL, DIV, arith, logic)
// Optional divider enabled by macro MIPS_ALU_UNIT_DIV_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module mips_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       aluop,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic             eq
);

  localparam logic [3:0] C_OP_SLL  = 4'd0;
  localparam logic [3:0] C_OP_SRA  = 4'd1;
  localparam logic [3:0] C_OP_SRL  = 4'd2;
  localparam logic [3:0] C_OP_MUL  = 4'd3;
  localparam logic [3:0] C_OP_DIV  = 4'd4;
  localparam logic [3:0] C_OP_ADD  = 4'd5;
  localparam logic [3:0] C_OP_SUB  = 4'd6;
  localparam logic [3:0] C_OP_AND  = 4'd7;
  localparam logic [3:0] C_OP_OR   = 4'd8;
  localparam logic [3:0] C_OP_XOR  = 4'd9;
  localparam logic [3:0] C_OP_NOR  = 4'd10;
  localparam logic [3:0] C_OP_SLT  = 4'd11;
  localparam logic [3:0] C_OP_SLTU = 4'd12;

  localparam logic [WIDTH-1:0] C_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]          r1_q, r1_d;
  logic [WIDTH-1:0]          r2_q, r2_d;
  logic                      eq_q, eq_d;
  logic [4:0]                w_sh;
  logic signed [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]          w_quot;
  logic [WIDTH-1:0]          w_rem;

  assign w_sh = y[4:0];

  // Explicit sign extension keeps the product a full-width signed multiply.
  assign w_prod = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{y[WIDTH-1]}}, y});

`ifdef MIPS_ALU_UNIT_DIV_EN
  logic w_div_zero;
  logic w_div_ovf;

  assign w_div_zero = (y == '0);
  assign w_div_ovf  = (x == C_INT_MIN) && (y == '1);

  // Divide-by-zero and INT_MIN/-1 are resolved here rather than left to the operator.
  always_comb begin
    w_quot = '0;
    w_rem  = '0;
    if (w_div_zero) begin
      w_quot = '1;
      w_rem  = x;
    end else if (w_div_ovf) begin
      w_quot = C_INT_MIN;
      w_rem  = '0;
    end else begin
      w_quot = $signed(x) / $signed(y);
      w_rem  = $signed(x) % $signed(y);
    end
  end
`else
  assign w_quot = '0;
  assign w_rem  = '0;
`endif

  always_comb begin
    r1_d = '0;
    r2_d = '0;
    eq_d = (x == y);
    case (aluop)
      C_OP_SLL:  r1_d = x << w_sh;
      C_OP_SRA:  r1_d = $signed(x) >>> w_sh;
      C_OP_SRL:  r1_d = x >> w_sh;
      C_OP_MUL: begin
        r1_d = w_prod[WIDTH-1:0];
        r2_d = w_prod[2*WIDTH-1:WIDTH];
      end
      C_OP_DIV: begin
        r1_d = w_quot;
        r2_d = w_rem;
      end
      C_OP_ADD:  r1_d = x + y;
      C_OP_SUB:  r1_d = x - y;
      C_OP_AND:  r1_d = x & y;
      C_OP_OR:   r1_d = x | y;
      C_OP_XOR:  r1_d = x ^ y;
      C_OP_NOR:  r1_d = ~(x | y);
      C_OP_SLT:  r1_d = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      C_OP_SLTU: r1_d = {{(WIDTH-1){1'b0}}, (x < y)};
      default:   r1_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_q <= '0;
      r2_q <= '0;
      eq_q <= 1'b0;
    end else if (en) begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      eq_q <= eq_d;
    end
  end

  assign r1 = r1_q;
  assign r2 = r2_q;
  assign eq = eq_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_alu_unit.sv
// ============================================================================
// tb_mips_alu_unit : directed + random self-checking bench for mips_alu_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mips_alu_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] x;
  logic [31:0] y;
  logic [3:0]  aluop;
  logic [31:0] r1;
  logic [31:0] r2;
  logic        eq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_r1;
  logic [31:0] m_r2;
  logic        m_eq;

  mips_alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .x     (x),
    .y     (y),
    .aluop (aluop),
    .r1    (r1),
    .r2    (r2),
    .eq    (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", tag, obs, exp);
    end
  endtask

  // Reference results computed in 64-bit integer arithmetic from the op rules.
  task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] e1, output logic [31:0] e2);
    longint sa;
    longint sb;
    longint ua;
    longint t;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    sh = int'(b[4:0]);
    e1 = '0;
    e2 = '0;
    case (op)
      4'd0: begin t = ua << sh;  e1 = t[31:0]; end
      4'd1: begin t = sa >>> sh; e1 = t[31:0]; end
      4'd2: begin t = ua >> sh;  e1 = t[31:0]; end
      4'd3: begin t = sa * sb; e1 = t[31:0]; e2 = t[63:32]; end
      4'd4: begin
`ifdef MIPS_ALU_UNIT_DIV_EN
        if (b == 32'd0) begin
          e1 = 32'hFFFF_FFFF;
          e2 = a;
        end else begin
          t = sa / sb; e1 = t[31:0];
          t = sa % sb; e2 = t[31:0];
        end
`endif
      end
      4'd5:  begin t = sa + sb; e1 = t[31:0]; end
      4'd6:  begin t = sa - sb; e1 = t[31:0]; end
      4'd7:  e1 = a & b;
      4'd8:  e1 = a | b;
      4'd9:  e1 = a ^ b;
      4'd10: e1 = ~(a | b);
      4'd11: e1 = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: e1 = (ua < longint'({32'b0, b})) ? 32'd1 : 32'd0;
      default: e1 = '0;
    endcase
  endtask

  task automatic step(input string tag, input logic rst, input logic e,
                      input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    rst_n = rst;
    en    = e;
    aluop = op;
    x     = a;
    y     = b;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_r1 = '0;
      m_r2 = '0;
      m_eq = 1'b0;
    end else if (e) begin
      alu_model(op, a, b, m_r1, m_r2);
      m_eq = (a == b);
    end
    check_value({tag, ".r1"}, r1, m_r1);
    check_value({tag, ".r2"}, r2, m_r2);
    check_value({tag, ".eq"}, {31'b0, eq}, {31'b0, m_eq});
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    aluop = 4'd0;
    x     = '0;
    y     = '0;
    m_r1  = '0;
    m_r2  = '0;
    m_eq  = 1'b0;

    step("reset", 1'b0, 1'b1, 4'd5, 32'd5, 32'd5);
    check_value("reset_r1", r1, 32'd0);
    step("first_add", 1'b1, 1'b1, 4'd5, 32'd5, 32'd5);
    check_value("first_add_val", r1, 32'd10);
    check_value("first_add_eq", {31'b0, eq}, 32'd1);

    step("add_wrap", 1'b1, 1'b1, 4'd5, 32'h7FFF_FFFF, 32'd1);
    check_value("add_wrap_val", r1, 32'h8000_0000);
    step("sub_wrap", 1'b1, 1'b1, 4'd6, 32'd0, 32'd1);
    check_value("sub_wrap_val", r1, 32'hFFFF_FFFF);
    step("nor", 1'b1, 1'b1, 4'd10, 32'd0, 32'd0);
    check_value("nor_val", r1, 32'hFFFF_FFFF);
    step("slt", 1'b1, 1'b1, 4'd11, 32'hFFFF_FFFF, 32'd1);
    check_value("slt_val", r1, 32'd1);
    step("sltu", 1'b1, 1'b1, 4'd12, 32'hFFFF_FFFF, 32'd1);
    check_value("sltu_val", r1, 32'd0);
    step("sra", 1'b1, 1'b1, 4'd1, 32'h8000_0000, 32'd33);
    check_value("sra_val", r1, 32'hC000_0000);
    step("srl", 1'b1, 1'b1, 4'd2, 32'h8000_0000, 32'd33);
    check_value("srl_val", r1, 32'h4000_0000);
    step("sll", 1'b1, 1'b1, 4'd0, 32'd1, 32'd31);
    check_value("sll_val", r1, 32'h8000_0000);
    step("mul", 1'b1, 1'b1, 4'd3, -32'sd3, 32'd7);
    check_value("mul_lo", r1, 32'hFFFF_FFEB);
    check_value("mul_hi", r2, 32'hFFFF_FFFF);

`ifdef MIPS_ALU_UNIT_DIV_EN
    step("div", 1'b1, 1'b1, 4'd4, -32'sd7, 32'd2);
    check_value("div_q", r1, -32'sd3);
    check_value("div_r", r2, -32'sd1);
    step("div0", 1'b1, 1'b1, 4'd4, 32'd9, 32'd0);
    check_value("div0_q", r1, 32'hFFFF_FFFF);
    check_value("div0_r", r2, 32'd9);
    step("divovf", 1'b1, 1'b1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check_value("divovf_q", r1, 32'h8000_0000);
    check_value("divovf_r", r2, 32'd0);
`else
    step("div_off", 1'b1, 1'b1, 4'd4, 32'd9, 32'd9);
    check_value("div_off_q", r1, 32'd0);
    check_value("div_off_eq", {31'b0, eq}, 32'd1);
`endif

    step("hold_load", 1'b1, 1'b1, 4'd5, 32'd2, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b1, 1'b0, 4'd6, 32'd9, 32'd1);
      check_value("hold_r1", r1, 32'd5);
      check_value("hold_eq", {31'b0, eq}, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      a  = pick_operand();
      b  = ($urandom_range(0, 3) == 0) ? a : pick_operand();
      op = 4'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0), op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
